// File: rtl/xor_parity_accumulator_if.sv
// Bus between a bit-stream source and the serial parity accumulator.
// The master drives frame control and data; the slave returns status and results.
interface xor_parity_accumulator_if #(
   parameter int FRAME_LEN = 8
) ();
   localparam int CW = $clog2(FRAME_LEN + 1);

   logic          start;
   logic          chk_en;
   logic          abort;
   logic          bit_in;
   logic          bit_valid;
   logic          busy;
   logic [CW-1:0] bit_count;
   logic          parity_out;
   logic          parity_err;
   logic          parity_valid;

   modport master (
      output start, chk_en, abort, bit_in, bit_valid,
      input  busy, bit_count, parity_out, parity_err, parity_valid
   );

   modport slave (
      input  start, chk_en, abort, bit_in, bit_valid,
      output busy, bit_count, parity_out, parity_err, parity_valid
   );
endinterface

// File: rtl/xor_parity_accumulator.sv
// Serial parity stage: folds a FRAME_LEN-bit stream through a single XOR and a
// one-bit feedback register, producing the frame parity or a check-mode error flag.
module xor_parity_accumulator #(
   parameter int FRAME_LEN = 8,
   parameter bit ODD       = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   xor_parity_accumulator_if.slave   bus
);
   localparam int            CW   = $clog2(FRAME_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic          r_acc;
   logic          r_mode;
   logic          r_parityOut;
   logic          r_parityErr;
   logic [CW-1:0] r_count;
   logic          w_startOk;
   logic          w_bitAccept;
   logic          w_lastBit;
   logic          w_xor;

   assign w_xor = r_acc ^ bus.bit_in;

   // Abort outranks both start and data; start is only honoured outside ACCUM.
   always_comb begin
      w_nextState = r_state;
      w_startOk   = 1'b0;
      w_bitAccept = 1'b0;
      w_lastBit   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               w_startOk   = 1'b1;
               w_nextState = ACCUM;
            end
         end
         ACCUM: begin
            if (bus.abort) begin
               w_nextState = IDLE;
            end else if (bus.bit_valid) begin
               w_bitAccept = 1'b1;
               if (r_count == LAST) begin
                  w_lastBit   = 1'b1;
                  w_nextState = DONE;
               end
            end
         end
         DONE: begin
            if (bus.start && !bus.abort) begin
               w_startOk   = 1'b1;
               w_nextState = ACCUM;
            end else begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Results are captured on the last-bit edge so they are already stable in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= 1'b0;
         r_mode      <= 1'b0;
         r_count     <= '0;
         r_parityOut <= 1'b0;
         r_parityErr <= 1'b0;
      end else if (w_startOk) begin
         r_acc       <= ODD;
         r_mode      <= bus.chk_en;
         r_count     <= '0;
         r_parityOut <= 1'b0;
         r_parityErr <= 1'b0;
      end else if (w_bitAccept) begin
         r_acc   <= w_xor;
         r_count <= r_count + 1'b1;
         if (w_lastBit) begin
            r_parityOut <= w_xor;
            r_parityErr <= r_mode & w_xor;
         end
      end
   end

   assign bus.busy         = (r_state == ACCUM);
   assign bus.parity_valid = (r_state == DONE);
   assign bus.bit_count    = r_count;
   assign bus.parity_out   = r_parityOut;
   assign bus.parity_err   = r_parityErr;
endmodule

// File: tb/tb_xor_parity_accumulator.sv
// Randomized scoreboard bench: an even-parity and an odd-parity instance share one
// stimulus stream; expected frame results come from ones-counting over the sent bits.
module tb_xor_parity_accumulator;
   localparam int FL = 8;

   logic clk;
   logic rst_n;
   logic start, chkEn, abortIn, bitIn, bitValid;

   int checks = 0;
   int errors = 0;

   logic [1:0] q0[$];
   logic [1:0] q1[$];
   logic [1:0] e0, e1;
   logic       holdOut0, holdErr0, holdOut1, holdErr1;

   xor_parity_accumulator_if #(.FRAME_LEN(FL)) bus0 ();
   xor_parity_accumulator_if #(.FRAME_LEN(FL)) bus1 ();

   assign bus0.start = start;    assign bus1.start = start;
   assign bus0.chk_en = chkEn;   assign bus1.chk_en = chkEn;
   assign bus0.abort = abortIn;  assign bus1.abort = abortIn;
   assign bus0.bit_in = bitIn;   assign bus1.bit_in = bitIn;
   assign bus0.bit_valid = bitValid; assign bus1.bit_valid = bitValid;

   xor_parity_accumulator #(.FRAME_LEN(FL), .ODD(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   xor_parity_accumulator #(.FRAME_LEN(FL), .ODD(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic rbit();
      return 1'($urandom_range(1, 0));
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic c, input logic a, input logic b, input logic v);
      start = s; chkEn = c; abortIn = a; bitIn = b; bitValid = v;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy0"}, int'(bus0.busy), 0);
      checkOutput({tag, "_count0"}, int'(bus0.bit_count), 0);
      checkOutput({tag, "_out0"}, int'(bus0.parity_out), 0);
      checkOutput({tag, "_err0"}, int'(bus0.parity_err), 0);
      checkOutput({tag, "_valid0"}, int'(bus0.parity_valid), 0);
      checkOutput({tag, "_busy1"}, int'(bus1.busy), 0);
      checkOutput({tag, "_out1"}, int'(bus1.parity_out), 0);
      checkOutput({tag, "_valid1"}, int'(bus1.parity_valid), 0);
   endtask

   task automatic checkHold(input string tag);
      checkOutput({tag, "_holdOut0"}, int'(bus0.parity_out), int'(holdOut0));
      checkOutput({tag, "_holdErr0"}, int'(bus0.parity_err), int'(holdErr0));
      checkOutput({tag, "_holdOut1"}, int'(bus1.parity_out), int'(holdOut1));
      checkOutput({tag, "_holdErr1"}, int'(bus1.parity_err), int'(holdErr1));
   endtask

   // Called in IDLE or DONE; the data bit offered alongside start must be dropped.
   task automatic startFrame(input logic chk);
      applyStimulus(1'b1, chk, 1'b0, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      holdOut0 = 1'b0; holdErr0 = 1'b0; holdOut1 = 1'b0; holdErr1 = 1'b0;
      checkOutput("startBusy", int'(bus0.busy), 1);
      checkOutput("startCount", int'(bus0.bit_count), 0);
      checkHold("start");
   endtask

   // bits[0] is sent first; abortAt < 0 means the frame runs to completion.
   task automatic sendBits(input logic [FL-1:0] bits, input logic chk, input int maxGap,
                           input int abortAt, input logic stressStart, output logic aborted);
      int ones = 0;
      logic p0, p1;
      aborted = 1'b0;
      for (int i = 0; i < FL; i++) begin
         int gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
         for (int g = 0; g < gap; g++) begin
            applyStimulus(stressStart & rbit(), rbit(), 1'b0, rbit(), 1'b0);
            tick();
         end
         if (i == abortAt) begin
            applyStimulus(1'b0, 1'b0, 1'b1, bits[i], rbit());
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            aborted = 1'b1;
            return;
         end
         if (bits[i]) ones++;
         if (i == FL - 1) begin
            p0 = 1'((ones + 0) % 2);
            p1 = 1'((ones + 1) % 2);
            holdOut0 = p0; holdErr0 = chk & p0;
            holdOut1 = p1; holdErr1 = chk & p1;
            q0.push_back({holdOut0, holdErr0});
            q1.push_back({holdOut1, holdErr1});
         end
         applyStimulus(1'b0, 1'b0, 1'b0, bits[i], 1'b1);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkDone(input string tag);
      checkOutput({tag, "_valid"}, int'(bus0.parity_valid), 1);
      checkOutput({tag, "_count"}, int'(bus0.bit_count), FL);
      checkOutput({tag, "_busy"}, int'(bus0.busy), 0);
      checkHold(tag);
   endtask

   task automatic idleCycles(input int n, input logic garbage);
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'b0, rbit(), 1'b0, rbit(), garbage & rbit());
         tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Scoreboard monitor: every result pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && bus0.parity_valid) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL pulse0: got unexpected result pulse, expected none at %0t", $time);
         end else begin
            e0 = q0.pop_front();
            checkOutput("scoreOut0", int'(bus0.parity_out), int'(e0[1]));
            checkOutput("scoreErr0", int'(bus0.parity_err), int'(e0[0]));
         end
      end
      if (rst_n && bus1.parity_valid) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL pulse1: got unexpected result pulse, expected none at %0t", $time);
         end else begin
            e1 = q1.pop_front();
            checkOutput("scoreOut1", int'(bus1.parity_out), int'(e1[1]));
            checkOutput("scoreErr1", int'(bus1.parity_err), int'(e1[0]));
         end
      end
   end

   initial begin
      logic ab;
      logic chk;
      int   abortAt;
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      holdOut0 = 1'b0; holdErr0 = 1'b0; holdOut1 = 1'b0; holdErr1 = 1'b0;
      #3;
      checkAllZero("reset");
      #9 rst_n = 1'b1;
      tick();

      $display("[TB] bits offered while idle are dropped");
      idleCycles(3, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("idleCount", int'(bus0.bit_count), 0);
      checkOutput("idleBusy", int'(bus0.busy), 0);

      $display("[TB] directed generate frame 1,0,1,1,0,0,1,0");
      startFrame(1'b0);
      sendBits(8'b01001101, 1'b0, 0, -1, 1'b0, ab);
      checkDone("gen");
      checkOutput("genOut0", int'(bus0.parity_out), 0);
      checkOutput("genOut1", int'(bus1.parity_out), 1);
      idleCycles(2, 1'b1);
      checkHold("genHold");

      $display("[TB] check mode, back-to-back frames");
      startFrame(1'b1);
      sendBits(8'b00001011, 1'b1, 0, -1, 1'b0, ab);
      checkDone("chkA");
      checkOutput("chkAErr0", int'(bus0.parity_err), 1);
      startFrame(1'b1);
      sendBits(8'b10001011, 1'b1, 0, -1, 1'b0, ab);
      checkDone("chkB");
      checkOutput("chkBErr0", int'(bus0.parity_err), 0);
      checkOutput("chkBErr1", int'(bus1.parity_err), 1);
      idleCycles(3, 1'b0);
      checkHold("chkBHold");

      $display("[TB] stalled frame with ignored start pulses");
      startFrame(1'b0);
      sendBits(8'b01001101, 1'b0, 3, -1, 1'b1, ab);
      checkDone("stall");

      $display("[TB] abort after five bits");
      startFrame(1'b1);
      sendBits(8'b11111111, 1'b1, 1, 5, 1'b0, ab);
      checkOutput("abort5Busy", int'(bus0.busy), 0);
      checkOutput("abort5Count", int'(bus0.bit_count), 5);
      checkHold("abort5");

      $display("[TB] start with abort in idle");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("startAbortBusy", int'(bus0.busy), 0);
      checkOutput("startAbortCount", int'(bus0.bit_count), 5);

      $display("[TB] abort on the last bit");
      startFrame(1'b0);
      sendBits(8'b10110101, 1'b0, 0, FL - 1, 1'b0, ab);
      checkOutput("abortLastBusy", int'(bus0.busy), 0);
      checkOutput("abortLastCount", int'(bus0.bit_count), FL - 1);
      idleCycles(2, 1'b0);

      $display("[TB] abort during the result cycle");
      startFrame(1'b1);
      sendBits(8'b00000001, 1'b1, 0, -1, 1'b0, ab);
      checkDone("abortDone");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("abortDoneBusy", int'(bus0.busy), 0);
      checkHold("abortDoneHold");

      $display("[TB] randomized frames");
      for (int f = 0; f < 30; f++) begin
         chk = rbit();
         abortAt = ($urandom_range(4, 0) == 0) ? int'($urandom_range(FL - 1, 0)) : -1;
         startFrame(chk);
         sendBits(FL'($urandom), chk, int'($urandom_range(3, 0)), abortAt, 1'b1, ab);
         if (ab) begin
            checkOutput("randAbortCount", int'(bus0.bit_count), abortAt);
            checkOutput("randAbortBusy", int'(bus0.busy), 0);
            checkHold("randAbort");
         end else begin
            checkDone("rand");
            if (rbit()) idleCycles(int'($urandom_range(3, 1)), 1'b1);
         end
      end
      idleCycles(2, 1'b0);
      checkHold("randHold");

      $display("[TB] reset in the middle of a frame");
      startFrame(1'b1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkAllZero("midReset");
      #10 rst_n = 1'b1;
      tick();
      checkAllZero("postReset");
      startFrame(1'b0);
      sendBits(8'hFF, 1'b0, 0, -1, 1'b0, ab);
      checkDone("ff");
      checkOutput("ffOut0", int'(bus0.parity_out), 0);
      checkOutput("ffOut1", int'(bus1.parity_out), 1);

      idleCycles(4, 1'b1);
      checkOutput("queueEmpty0", q0.size(), 0);
      checkOutput("queueEmpty1", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/xor_parity_accumulator.md
Name: xor_parity_accumulator

Overview:
- Serial parity stage that consumes a bit stream and XOR-reduces it over a fixed-length frame, one bit per accepted cycle.
- Sits directly downstream of the single XOR gate cell: the two-input XOR is its combinational core, folded through a one-bit feedback register.
- Two modes: generate (outputs the frame parity bit) or check (flags a parity error on a frame that already carries its parity bit).

Parameters:
- FRAME_LEN, 8, number of bits per frame (legal range 2..255); in check mode this count includes the parity bit.
- ODD, 0, parity sense: 0 = even, 1 = odd.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a frame; sampled only in IDLE or DONE
- chk_en  input  1  mode select, latched on accepted start: 0 = generate, 1 = check
- abort  input  1  synchronous frame cancel
- bit_in  input  1  serial data bit
- bit_valid  input  1  bit_in is valid this cycle
- busy  output  1  high in ACCUM
- bit_count  output  $clog2(FRAME_LEN+1)  bits accepted in the current frame
- parity_out  output  1  accumulated parity
- parity_err  output  1  check-mode mismatch
- parity_valid  output  1  one-cycle pulse: result ready

Behaviour:
- Async reset (rst_n low):
  - state = IDLE.
  - acc, bit_count, parity_out, parity_err, parity_valid and busy all go to 0, immediately and without waiting for clk.
  - chk_en latch cleared to 0.
- States and transitions:
  - IDLE: start=1 and abort=0 → ACCUM.
  - ACCUM: accepted bit with bit_count == FRAME_LEN-1 → DONE; abort=1 → IDLE.
  - DONE: lasts exactly one cycle. Goes to ACCUM if start=1 and abort=0, otherwise IDLE.
- On an accepted start:
  - acc ← ODD, bit_count ← 0, mode latch ← chk_en.
  - parity_err ← 0 and parity_out ← 0 (previous results cleared).
- Bit acceptance: only in ACCUM with bit_valid=1 and abort=0.
  - acc ← acc ^ bit_in; bit_count ← bit_count+1.
  - bit_valid=0 stalls the frame with no change.
- bit_valid outside ACCUM is ignored; those bits are dropped, not buffered.
- The bit presented in the same cycle as start is NOT accepted. The first bit is accepted the cycle after start.
- Result latency: parity_valid=1 during DONE, i.e. the cycle after the last accepted bit. In that same cycle:
  - parity_out = final acc.
  - Generate mode: parity_err = 0.
  - Check mode: parity_err = final acc (any nonzero means the frame violates the selected parity sense).
- parity_out and parity_err hold their values after DONE until the next accepted start or reset.
- Arithmetic: acc is 1 bit. bit_count never exceeds FRAME_LEN and wraps to 0 only via start.
- Boundary conditions:
  - start while in ACCUM: ignored; the frame continues.
  - abort with start in the same cycle: abort wins, stays or returns to IDLE.
  - abort in ACCUM: no parity_valid pulse; parity_out/parity_err keep their prior held values.
  - abort in the same cycle as the last bit: the bit is not accepted, state → IDLE, no pulse.
  - abort in DONE: the pulse still occurs this cycle; next state is IDLE.
  - Back-to-back frames: start during DONE gives zero idle cycles between frames.
  - Reset mid-frame: immediate return to IDLE with all outputs 0. No pulse after reset is released.

Test Plan:
- Generate, FRAME_LEN=8, ODD=0: start, then bits 1,0,1,1,0,0,1,0 on consecutive cycles → parity_valid pulses 1 cycle after the 8th bit, parity_out=0, parity_err=0, bit_count=8. Repeat with ODD=1 → parity_out=1.
- Check, ODD=0: start with chk_en=1, frame 1,1,0,1,0,0,0,0 → parity_err=1. Frame 1,1,0,1,0,0,0,1 → parity_err=0. Both results hold after DONE.
- Stalls: insert bit_valid=0 gaps of 1–3 cycles inside a frame, and assert bit_valid in IDLE before start → same parity as the gapless frame; IDLE bits ignored; bit_count counts only accepted bits.
- Back-to-back: assert start in the DONE cycle of frame 1 → frame 2 accumulates from a fresh acc=ODD, result unaffected by frame 1, no idle cycle between frames.
- Abort/start races: abort after 5 bits → no pulse, busy=0 next cycle. start+abort together in IDLE → stays IDLE. abort coincident with the 8th bit → no pulse, bit_count stays 7.
- Reset: drop rst_n mid-clock after 4 bits → all outputs 0 before the next edge. After release, a full frame 0xFF (ODD=0) → parity_out=0.
